exec_wb: RTL and testbench
==========================

EXEC_WB -- requirements
Module: exec_wb

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered results; power of two, at least 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  exec stage presents a result.
REQ-005 SHALL have port: in_ready  output  1  buffer accepts the result this cycle.
REQ-006 SHALL have port: in_result  input  exec_result  rd_idx, rd_val, br_valid, br_target from exec.
REQ-007 SHALL have port: wb_valid  output  1  register-file write request.
REQ-008 SHALL have port: wb_ready  input  1  register file grants the write.
REQ-009 SHALL have port: wb_idx  output  5  destination register.
REQ-010 SHALL have port: wb_val  output  32  write data.
REQ-011 SHALL have port: redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-012 SHALL have port: redirect_target  output  32  redirect PC.
REQ-013 SHALL have port: flush  input  1  discard all buffered results.

Function
REQ-014 SHALL accept a result on in_valid && in_ready, with enqueue visible at head no earlier than the next cycle.
REQ-015 SHALL drive in_ready = (state==RUN) && (count<DEPTH) && !flush, with no same-cycle full bypass.
REQ-016 SHALL accept a result with rd_idx==0 && !br_valid without storing it.
REQ-017 SHALL drive wb_valid = !empty && head.rd_idx!=0 && !flush and pop on wb_valid && wb_ready; wb_idx/wb_val come from the head.
REQ-018 SHALL pop a head with rd_idx==0 && br_valid in one cycle without a write.
REQ-019 SHALL drain in strict FIFO order, with read/write pointers wrapping modulo DEPTH.
REQ-020 SHALL update count by +1/-1/0 when enqueue and pop occur in the same cycle, and SHALL keep it in 0..DEPTH.
REQ-021 SHALL implement an FSM with states RUN, BR_WAIT and REDIRECT.
REQ-022 SHALL go RUN->BR_WAIT on enqueue with br_valid, holding in_ready low because younger results are wrong-path.
REQ-023 SHALL go BR_WAIT->REDIRECT when the branch entry pops, after its link write if rd_idx!=0; the branch entry is always the last entry.
REQ-024 SHALL, in REDIRECT, assert redirect_valid for exactly one cycle with the stored br_target, then return to RUN.
REQ-025 SHALL, on flush, clear the FIFO (count=0, pointers equal) and force state RUN on the next edge.
REQ-026 SHALL give flush priority: no enqueue, no pop and redirect_valid=0 that cycle.
REQ-027 SHALL hold wb_idx/wb_val stable while wb_valid && !wb_ready.

Reset
REQ-028 SHALL, on rst, asynchronously clear count, pointers and state to RUN, and drive wb_valid=0, redirect_valid=0, in_ready=0.
REQ-029 SHALL drive wb_idx=0, wb_val=0 and redirect_target=0 during reset.
REQ-030 SHALL discard any in-flight branch pending from BR_WAIT or REDIRECT when reset asserts mid-operation; no redirect is emitted.
REQ-031 SHALL not require entry storage to be reset, as long as no output exposes it while empty.

Structure
REQ-032 SHALL define the wb_state_e enum (RUN/BR_WAIT/REDIRECT) and WB_DEPTH default in the shared types package next to exec_result.
REQ-033 SHALL use one sub-module: sync_fifo (parameterised width/depth, push/pop/count, synchronous clear).

Verification
REQ-034 SHALL cover: 5 back-to-back results rd=1..5, wb_ready=1 -> 4 accepted, in_ready low one cycle, writes in order x1..x5.
REQ-035 SHALL cover: wb_ready=0 for 10 cycles with 4 queued -> in_ready=0, wb_idx/wb_val stable; release -> 4 writes in 4 cycles.
REQ-036 SHALL cover: branch rd=1 val=0x104 target=0x200 -> write x1=0x104, then redirect_valid 1 cycle target=0x200; in_ready low until RUN.
REQ-037 SHALL cover: result rd=0 val=0xDEAD -> accepted, no wb_valid; branch rd=0 target=0x80 -> no write, redirect 0x80.
REQ-038 SHALL cover: flush with 3 queued plus in_valid and a pending branch -> nothing accepted or written, no redirect, empty next cycle.
REQ-039 SHALL cover: rst asserted mid-drain -> outputs 0 immediately (async); after release, a new result rd=7 writes x7 correctly.

Source files
------------

// File: rtl/exec_wb_pkg.sv
// Shared types for the exec-to-writeback buffer:
// the exec result bundle, FSM states and default depth.
package exec_wb_pkg;

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd_idx;
    logic [31:0] rd_val;
    logic        br_valid;
    logic [31:0] br_target;
  } exec_result;

  typedef enum logic [1:0] {
    RUN,
    BR_WAIT,
    REDIRECT
  } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two FIFO with occupancy count and synchronous clear.
// Entry storage is not reset; callers must gate rdata_o on empty_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (cnt_q != FULL) && !clr_i;
  assign do_pop  = pop_i && (cnt_q != '0) && !clr_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)
        cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/exec_wb.sv
// Writeback buffer between exec and the register file; holds
// intake after a branch until its redirect pulse has been sent.
module exec_wb
  import exec_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  exec_result  in_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_idx,
  output logic [31:0] wb_val,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic        flush
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_state_e   state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  exec_result  head;
  logic [CW-1:0] count;
  logic        empty;
  logic        push;
  logic        pop;
  logic        head_wr;

  assign in_ready = !rst && (state_q == RUN) &&
                    (count < DEPTH_C) && !flush;

  // Plain rd=0 results carry nothing to write or redirect.
  assign push = in_valid && in_ready &&
                ((in_result.rd_idx != '0) || in_result.br_valid);

  assign head_wr  = !empty && (head.rd_idx != '0);
  assign wb_valid = head_wr && !flush;

  // A stored rd=0 head is always a branch: retire it unconditionally.
  assign pop = !flush && !empty &&
               (head_wr ? wb_ready : 1'b1);

  assign wb_idx = empty ? '0 : head.rd_idx;
  assign wb_val = empty ? '0 : head.rd_val;

  assign redirect_valid  = (state_q == REDIRECT) && !flush;
  assign redirect_target = tgt_q;

  sync_fifo #(
    .WIDTH ($bits(exec_result)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_result),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (push && in_result.br_valid)
            state_d = BR_WAIT;
        end
        BR_WAIT: begin
          if (pop && head.br_valid) begin
            state_d = REDIRECT;
            tgt_d   = head.br_target;
          end
        end
        REDIRECT: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_exec_wb.sv
// Scoreboard bench for exec_wb: expected writes are queued on
// accept and retired as the register-file handshake fires.
module tb_exec_wb;
  import exec_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  exec_result  in_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;

  int checks = 0;
  int errors = 0;
  int redir_cnt = 0;
  logic [31:0] redir_tgt;
  logic [36:0] exp_q [$];

  exec_wb dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_result       (in_result),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_idx          (wb_idx),
    .wb_val          (wb_val),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .flush           (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; this samples after they settle,
  // i.e. the values the next rising edge will act on.
  always @(negedge clk) begin
    logic [36:0] e;
    #2;
    if (!rst && wb_valid && wb_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got x%0d=%h required none",
                 wb_idx, wb_val);
      end else begin
        e = exp_q.pop_front();
        if ({wb_idx, wb_val} !== e) begin
          errors++;
          $display("FAIL wb_order got x%0d=%h required x%0d=%h",
                   wb_idx, wb_val, e[36:32], e[31:0]);
        end
      end
    end
    if (!rst && redirect_valid) begin
      redir_cnt++;
      redir_tgt = redirect_target;
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd,
                       input logic [31:0] val, input logic br,
                       input logic [31:0] tgt);
    in_valid            = v;
    in_result.rd_idx    = rd;
    in_result.rd_val    = val;
    in_result.br_valid  = br;
    in_result.br_target = tgt;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d left required 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, wb_valid, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b required 000",
               {in_ready, wb_valid, redirect_valid});
    end
    checks++;
    if ({wb_idx, wb_val, redirect_target} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h required 0",
               wb_idx, wb_val, redirect_target);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(100 + i), 1'b0, '0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_acc%0d got %b required 1", i, in_ready);
      end
      exp_q.push_back({5'(i), 32'(100 + i)});
    end
    @(negedge clk);
    wb_ready = 1'b1;
    drive(1'b1, 5'd5, 32'd105, 1'b0, '0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got %b required 0", in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resume got %b required 1", in_ready);
    end
    exp_q.push_back({5'd5, 32'd105});
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    wait_drain("b2b");
  endtask

  task automatic test_stall;
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(11 + i), 32'hA000 + 32'(i), 1'b0, '0);
      exp_q.push_back({5'(11 + i), 32'hA000 + 32'(i)});
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd20, 32'hBAD, 1'b0, '0);
      #1;
      checks++;
      if ({in_ready, wb_valid, wb_idx, wb_val} !==
          {1'b0, 1'b1, 5'd11, 32'hA000}) begin
        errors++;
        $display("FAIL stall_hold c%0d got %b%b x%0d=%h required 01 x11=a000",
                 c, in_ready, wb_valid, wb_idx, wb_val);
      end
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_4cyc got %0d left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_branch;
    redir_cnt = 0;
    wb_ready  = 1'b1;
    @(negedge clk);
    drive(1'b1, 5'd1, 32'h104, 1'b1, 32'h200);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL br_acc got %b required 1", in_ready);
    end
    exp_q.push_back({5'd1, 32'h104});
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h999, 1'b0, '0);
    #1;
    checks++;
    if ({in_ready, redirect_valid} !== 2'b00) begin
      errors++;
      $display("FAIL br_wait got %b required 00",
               {in_ready, redirect_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, redirect_valid, redirect_target} !==
        {2'b01, 32'h200}) begin
      errors++;
      $display("FAIL br_redir got %b %h required 01 200",
               {in_ready, redirect_valid}, redirect_target);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    checks++;
    if ({in_ready, redirect_valid} !== 2'b10) begin
      errors++;
      $display("FAIL br_run got %b required 10",
               {in_ready, redirect_valid});
    end
    #2;
    checks++;
    if (redir_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL br_pulse got %0d/%0d required 1/0",
               redir_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rd0;
    redir_cnt = 0;
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, '0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd0_acc got %b required 1", in_ready);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd0_nowr got %b required 0", wb_valid);
    end
    @(negedge clk);
    drive(1'b1, 5'd0, 32'h0, 1'b1, 32'h80);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    checks++;
    if ({wb_valid, redirect_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rd0br_nowr got %b required 00",
               {wb_valid, redirect_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({redirect_valid, redirect_target} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL rd0br_redir got %b %h required 1 80",
               redirect_valid, redirect_target);
    end
    @(negedge clk);
    #3;
    checks++;
    if (redir_cnt != 1 || redir_tgt !== 32'h80) begin
      errors++;
      $display("FAIL rd0br_pulse got %0d %h required 1 80",
               redir_cnt, redir_tgt);
    end
  endtask

  task automatic test_flush;
    redir_cnt = 0;
    wb_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(21 + i), 32'hF0 + 32'(i), i == 2, 32'h300);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fl_fill%0d got %b required 1", i, in_ready);
      end
    end
    @(negedge clk);
    flush    = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, 5'd25, 32'h25, 1'b0, '0);
    #1;
    checks++;
    if ({in_ready, wb_valid, redirect_valid} !== 3'b000) begin
      errors++;
      $display("FAIL fl_prio got %b required 000",
               {in_ready, wb_valid, redirect_valid});
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    #1;
    checks++;
    if ({in_ready, wb_valid, wb_idx} !== {2'b10, 5'd0}) begin
      errors++;
      $display("FAIL fl_empty got %b x%0d required 10 x0",
               {in_ready, wb_valid}, wb_idx);
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (redir_cnt != 0) begin
      errors++;
      $display("FAIL fl_noredir got %0d required 0", redir_cnt);
    end
  endtask

  task automatic test_reset_mid;
    redir_cnt = 0;
    wb_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, i == 2 ? 5'd0 : 5'(31 + i),
            32'hC0 + 32'(i), i == 2, 32'h400);
    end
    exp_q.push_back({5'd31, 32'hC0});
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    wb_ready = 1'b1;
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, in_ready, redirect_valid, wb_idx, wb_val} !== '0) begin
      errors++;
      $display("FAIL rstmid_out got %b%b%b x%0d=%h required 0",
               wb_valid, in_ready, redirect_valid, wb_idx, wb_val);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_idle got %b required 01",
               {wb_valid, in_ready});
    end
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h77, 1'b0, '0);
    exp_q.push_back({5'd7, 32'h77});
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0);
    wait_drain("rstmid");
    checks++;
    if (redir_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_noredir got %0d required 0", redir_cnt);
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    test_reset();
    test_back_to_back();
    test_stall();
    test_branch();
    test_rd0();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running required done");
    $fatal(1);
  end

endmodule
